// File: rtl/afe_ads_capture.sv
// rtl/afe_ads_capture.sv - AFE sample capture: settle, ADC convert, SPI read, tagged 4-deep output buffer
module afe_ads_capture #(
    parameter int NUM_CH       = 64,
    parameter int CH_W         = 7,
    parameter int T_SETTLE     = 20,
    parameter int T_CONV_PULSE = 3,
    parameter int T_BUSY_MAX   = 60,
    parameter int SCLK_DIV     = 1
) (
    input  logic            CLK_100M,
    input  logic            CLK_RST,
    input  logic            ADS_INIT_OK,
    input  logic            AFE_CLK,
    input  logic            AFE_STI,
    output logic            ADS_CONVST,
    input  logic            ADS_BUSY,
    output logic            ADS_CS_N,
    output logic            ADS_SCLK,
    input  logic            ADS_SDO,
    output logic [15:0]     DOUT_DATA,
    output logic [CH_W-1:0] DOUT_CH,
    output logic            DOUT_VALID,
    input  logic            DOUT_READY,
    output logic            FRAME_DONE,
    output logic            OVERFLOW,
    output logic            BUSY_TO,
    output logic            EDGE_MISS
);
    localparam int CNT_W   = 8;
    localparam int ENTRY_W = 16 + CH_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CONV, S_WAIT_BUSY, S_SHIFT, S_PUSH, S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic               afe_clk_q, afe_clk_d, sti_q, sti_d;
    logic               afe_rise, sti_rise;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]        shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
    logic               overflow_q, overflow_d, busy_to_q, busy_to_d, edge_miss_q, edge_miss_d;
    logic [ENTRY_W-1:0] mem_q [4];
    logic [ENTRY_W-1:0] mem_d [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;
    logic               div_wrap, shift_done, busy_timeout, push, pop, full, wr_en;

    assign afe_rise     = AFE_CLK & ~afe_clk_q;
    assign sti_rise     = AFE_STI & ~sti_q;
    assign div_wrap     = (cnt_q == CNT_W'(SCLK_DIV - 1));
    assign shift_done   = div_wrap && !sclk_q && (bit_cnt_q == 5'd16);
    assign busy_timeout = (state_q == S_WAIT_BUSY) && ADS_BUSY && (cnt_q == CNT_W'(T_BUSY_MAX - 1));

    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sti_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (afe_rise && ADS_INIT_OK && (ch_cnt_q < CH_W'(NUM_CH))) state_d = S_SETTLE;
                S_SETTLE:    if (cnt_q == CNT_W'(T_SETTLE - 1)) state_d = S_CONV;
                S_CONV:      if (cnt_q == CNT_W'(T_CONV_PULSE - 1)) state_d = S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    // BUSY is not trusted for the first two cycles after CONVST drops
                    if ((cnt_q >= CNT_W'(2)) && !ADS_BUSY) state_d = S_SHIFT;
                    else if (busy_timeout)                  state_d = S_NEXT;
                end
                S_SHIFT:     if (shift_done) state_d = S_PUSH;
                S_PUSH:      state_d = S_NEXT;
                S_NEXT:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ADS_CONVST = 1'b0;
        ADS_CS_N   = 1'b1;
        push       = 1'b0;
        FRAME_DONE = 1'b0;
        case (state_q)
            S_CONV:  ADS_CONVST = 1'b1;
            S_SHIFT: ADS_CS_N   = 1'b0;
            S_PUSH:  push       = !sti_rise;
            S_NEXT:  FRAME_DONE = !sti_rise && (ch_cnt_q == CH_W'(NUM_CH - 1));
            default: ;
        endcase
    end

    always_comb begin
        afe_clk_d = AFE_CLK;
        sti_d     = AFE_STI;

        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == S_IDLE || state_d != state_q) cnt_d = '0;
        else if (state_q == S_SHIFT && div_wrap)     cnt_d = '0;

        // SDO is captured on the cycle SCLK is driven high, one bit per SCLK period
        sclk_d    = sclk_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (state_q == S_SHIFT && !sti_rise) begin
            if (div_wrap) begin
                if (sclk_q) begin
                    sclk_d = 1'b0;
                end else if (bit_cnt_q != 5'd16) begin
                    sclk_d    = 1'b1;
                    shreg_d   = {shreg_q[14:0], ADS_SDO};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = 5'd0;
        end

        ch_cnt_d = ch_cnt_q;
        if (sti_rise)                ch_cnt_d = '0;
        else if (state_q == S_NEXT)  ch_cnt_d = ch_cnt_q + CH_W'(1);

        pop      = (count_q != 3'd0) && DOUT_READY;
        full     = (count_q == 3'd4);
        wr_en    = push && (!full || pop);
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = {shreg_q, ch_cnt_q};
        wr_ptr_d = wr_ptr_q + {1'b0, wr_en};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + {2'b00, wr_en} - {2'b00, pop};

        overflow_d  = overflow_q | (push && full && !pop);
        busy_to_d   = busy_to_q | busy_timeout;
        edge_miss_d = edge_miss_q | (afe_rise && state_q != S_IDLE);
        if (sti_rise) begin
            overflow_d  = 1'b0;
            busy_to_d   = 1'b0;
            edge_miss_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            afe_clk_q   <= 1'b0;
            sti_q       <= 1'b0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            sclk_q      <= 1'b0;
            ch_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            busy_to_q   <= 1'b0;
            edge_miss_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            afe_clk_q   <= afe_clk_d;
            sti_q       <= sti_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            sclk_q      <= sclk_d;
            ch_cnt_q    <= ch_cnt_d;
            overflow_q  <= overflow_d;
            busy_to_q   <= busy_to_d;
            edge_miss_q <= edge_miss_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign ADS_SCLK   = sclk_q;
    assign DOUT_DATA  = mem_q[rd_ptr_q][ENTRY_W-1:CH_W];
    assign DOUT_CH    = mem_q[rd_ptr_q][CH_W-1:0];
    assign DOUT_VALID = (count_q != 3'd0);
    assign OVERFLOW   = overflow_q;
    assign BUSY_TO    = busy_to_q;
    assign EDGE_MISS  = edge_miss_q;
endmodule

// File: tb/tb_afe_ads_capture.sv
// tb/tb_afe_ads_capture.sv - directed self-checking bench for afe_ads_capture
`timescale 1ns/1ps
module tb_afe_ads_capture;
    localparam int BUSY_LEN = 8;

    logic        CLK_100M = 1'b0;
    logic        CLK_RST = 1'b1;
    logic        ADS_INIT_OK = 1'b0;
    logic        AFE_CLK = 1'b0;
    logic        AFE_STI = 1'b0;
    logic        DOUT_READY = 1'b0;
    logic        ADS_BUSY, ADS_SDO;
    logic        ADS_CONVST, ADS_CS_N, ADS_SCLK, DOUT_VALID, FRAME_DONE, OVERFLOW, BUSY_TO, EDGE_MISS;
    logic [15:0] DOUT_DATA;
    logic [6:0]  DOUT_CH;

    int n_cmp = 0;
    int n_err = 0;

    logic        busy_hold = 1'b0;
    logic        adc_ramp = 1'b0;
    logic [15:0] adc_fixed = 16'h0000;
    logic [15:0] adc_word;
    int          busy_cnt = 0;
    int          conv_idx = 0;
    int          conv_base = 0;
    int          sclk_rises = 0;
    int          sclk_falls = 0;
    int          cs_base = 0;
    int          sdo_idx;
    int          fd_cnt = 0;
    logic [22:0] got_q[$];

    always #5 CLK_100M = ~CLK_100M;

    afe_ads_capture dut (
        .CLK_100M(CLK_100M), .CLK_RST(CLK_RST), .ADS_INIT_OK(ADS_INIT_OK),
        .AFE_CLK(AFE_CLK), .AFE_STI(AFE_STI), .ADS_CONVST(ADS_CONVST),
        .ADS_BUSY(ADS_BUSY), .ADS_CS_N(ADS_CS_N), .ADS_SCLK(ADS_SCLK),
        .ADS_SDO(ADS_SDO), .DOUT_DATA(DOUT_DATA), .DOUT_CH(DOUT_CH),
        .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW), .BUSY_TO(BUSY_TO), .EDGE_MISS(EDGE_MISS)
    );

    // ADC model: BUSY follows CONVST, SDO presents MSB at CS_N fall and advances on SCLK fall
    always @(posedge CLK_100M) begin
        if (ADS_CONVST)        busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (FRAME_DONE) fd_cnt <= fd_cnt + 1;
        if (DOUT_VALID && DOUT_READY) got_q.push_back({DOUT_DATA, DOUT_CH});
    end
    assign ADS_BUSY = busy_hold || (busy_cnt != 0);
    always @(posedge ADS_CONVST) conv_idx <= conv_idx + 1;
    always @(posedge ADS_SCLK) sclk_rises <= sclk_rises + 1;
    always @(negedge ADS_SCLK) sclk_falls <= sclk_falls + 1;
    always @(negedge ADS_CS_N) cs_base <= sclk_falls;
    always_comb begin
        adc_word = adc_ramp ? (16'hA000 + 16'(conv_idx - conv_base - 1)) : adc_fixed;
        sdo_idx  = 15 - (sclk_falls - cs_base);
        if (sdo_idx < 0) sdo_idx = 0;
    end
    assign ADS_SDO = adc_word[4'(sdo_idx)];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st();
        return {ADS_CONVST, ADS_CS_N, ADS_SCLK, DOUT_VALID, FRAME_DONE, OVERFLOW, BUSY_TO, EDGE_MISS};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK_100M);
    endtask

    task automatic sti_pulse();
        @(negedge CLK_100M);
        AFE_STI   = 1'b1;
        conv_base = conv_idx;
        @(negedge CLK_100M);
        AFE_STI   = 1'b0;
    endtask

    task automatic afe_period();
        @(negedge CLK_100M);
        AFE_CLK = 1'b1;
        cycles(64);
        AFE_CLK = 1'b0;
        cycles(65);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            @(negedge CLK_100M);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fd0, cv0, sr0;

        // reset state
        cycles(3);
        check("reset_status", 32'(st()), 32'h40);
        check("reset_dout", 32'({DOUT_DATA, DOUT_CH}), 32'h0);
        CLK_RST     = 1'b0;
        ADS_INIT_OK = 1'b1;
        DOUT_READY  = 1'b1;
        cycles(2);

        // single conversion: CONVST window, SPI bit order
        adc_ramp  = 1'b0;
        adc_fixed = 16'h8001;
        sti_pulse();
        base = got_q.size(); sr0 = sclk_rises; fd0 = fd_cnt;
        @(negedge CLK_100M);
        AFE_CLK = 1'b1;
        cycles(20); check("convst_n20", 32'(ADS_CONVST), 32'd0);
        cycles(1);  check("convst_n21", 32'(ADS_CONVST), 32'd1);
        cycles(2);  check("convst_n23", 32'(ADS_CONVST), 32'd1);
        cycles(1);  check("convst_n24", 32'(ADS_CONVST), 32'd0);
        AFE_CLK = 1'b0;
        wait_words(base + 1, 200);
        check("single_count", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("single_word", 32'(got_q[base]), 32'({16'h8001, 7'd0}));
        check("single_sclk_rises", 32'(sclk_rises - sr0), 32'd16);
        cycles(3);
        check("single_status", 32'(st()), 32'h40);
        check("single_no_frame_done", 32'(fd_cnt - fd0), 32'd0);

        // full frame at AFE rate
        adc_ramp = 1'b1;
        sti_pulse();
        base = got_q.size(); fd0 = fd_cnt;
        repeat (64) afe_period();
        wait_words(base + 64, 200);
        check("frame_count", 32'(got_q.size() - base), 32'd64);
        for (int i = 0; i < 64 && (base + i) < got_q.size(); i++)
            check($sformatf("frame_word_%0d", i), 32'(got_q[base + i]), 32'({16'hA000 + 16'(i), 7'(i)}));
        check("frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
        check("frame_flags", 32'({OVERFLOW, BUSY_TO, EDGE_MISS}), 32'd0);
        cv0 = conv_idx; base = got_q.size();
        afe_period();
        check("post_frame_no_conv", 32'(conv_idx - cv0), 32'd0);
        check("post_frame_no_word", 32'(got_q.size() - base), 32'd0);
        check("post_frame_no_miss", 32'(EDGE_MISS), 32'd0);

        // consumer stalled for a whole frame
        DOUT_READY = 1'b0;
        sti_pulse();
        base = got_q.size(); fd0 = fd_cnt;
        repeat (4) afe_period();
        check("ovf_4_words", 32'({DOUT_VALID, OVERFLOW, DOUT_DATA, DOUT_CH}), 32'({1'b1, 1'b0, 16'hA000, 7'd0}));
        afe_period();
        check("ovf_after_5th", 32'({DOUT_VALID, OVERFLOW, DOUT_DATA, DOUT_CH}), 32'({1'b1, 1'b1, 16'hA000, 7'd0}));
        repeat (59) afe_period();
        check("ovf_head_held", 32'({DOUT_DATA, DOUT_CH}), 32'({16'hA000, 7'd0}));
        check("ovf_frame_done", 32'(fd_cnt - fd0), 32'd1);
        DOUT_READY = 1'b1;
        cycles(10);
        check("ovf_drain_count", 32'(got_q.size() - base), 32'd4);
        for (int i = 0; i < 4 && (base + i) < got_q.size(); i++)
            check($sformatf("ovf_drain_%0d", i), 32'(got_q[base + i]), 32'({16'hA000 + 16'(i), 7'(i)}));
        check("ovf_drained_valid", 32'(DOUT_VALID), 32'd0);

        // BUSY stuck high
        busy_hold = 1'b1;
        sti_pulse();
        check("sti_clears_ovf", 32'(OVERFLOW), 32'd0);
        base = got_q.size();
        @(negedge CLK_100M);
        AFE_CLK = 1'b1;
        cycles(83); check("bto_n83", 32'(BUSY_TO), 32'd0);
        cycles(1);  check("bto_n84", 32'(BUSY_TO), 32'd1);
        AFE_CLK = 1'b0;
        cycles(40);
        busy_hold = 1'b0;
        check("bto_no_push", 32'(got_q.size() - base), 32'd0);
        cycles(10);
        afe_period();
        wait_words(base + 1, 200);
        check("bto_next_count", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("bto_next_word", 32'(got_q[base]), 32'({16'hA001, 7'd1}));
        check("bto_sticky", 32'(BUSY_TO), 32'd1);

        // second AFE edge during SPI shift
        sti_pulse();
        check("sti_clears_bto", 32'(BUSY_TO), 32'd0);
        base = got_q.size(); cv0 = conv_idx;
        @(negedge CLK_100M);
        AFE_CLK = 1'b1;
        cycles(5);
        AFE_CLK = 1'b0;
        cycles(35);
        AFE_CLK = 1'b1;
        check("miss_in_shift_csn", 32'(ADS_CS_N), 32'd0);
        cycles(1);
        check("edge_miss_set", 32'(EDGE_MISS), 32'd1);
        cycles(100);
        AFE_CLK = 1'b0;
        check("miss_word_count", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("miss_word", 32'(got_q[base]), 32'({16'hA000, 7'd0}));
        check("miss_single_conv", 32'(conv_idx - cv0), 32'd1);
        cycles(30);
        sti_pulse();
        check("sti_clears_miss", 32'(EDGE_MISS), 32'd0);
        base = got_q.size();
        afe_period();
        wait_words(base + 1, 200);
        check("sti_restart_count", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("sti_restart_ch0", 32'(got_q[base]), 32'({16'hA000, 7'd0}));

        // reset during SPI shift, then INIT_OK low
        DOUT_READY = 1'b0;
        afe_period();
        @(negedge CLK_100M);
        AFE_CLK = 1'b1;
        cycles(5);
        AFE_CLK = 1'b0;
        cycles(35);
        AFE_CLK = 1'b1;
        cycles(5);
        check("pre_reset", 32'({ADS_CS_N, DOUT_VALID, EDGE_MISS}), 32'b011);
        CLK_RST = 1'b1;
        cycles(1);
        check("reset_mid_shift", 32'(st()), 32'h40);
        CLK_RST     = 1'b0;
        ADS_INIT_OK = 1'b0;
        DOUT_READY  = 1'b1;
        cv0 = conv_idx; base = got_q.size();
        cycles(1);
        AFE_CLK = 1'b0;
        cycles(5);
        afe_period();
        afe_period();
        check("init_low_no_conv", 32'(conv_idx - cv0), 32'd0);
        check("init_low_no_word", 32'(got_q.size() - base), 32'd0);
        check("init_low_status", 32'(st()), 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
